// File: rtl/cla_pkg.sv
// Shared constants and width validation for the carry-lookahead adder.
package cla_pkg;

    localparam int CLA_GROUP_W    = 4;
    localparam int CLA_MAX_GROUPS = 4;

    function automatic bit cla_width_ok(input int width);
        return (width > 0) && (width % CLA_GROUP_W == 0) &&
               (width <= CLA_GROUP_W * CLA_MAX_GROUPS);
    endfunction

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit lookahead group: flat sum-of-products carries plus group P/G.
module cla4_group
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       gp,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is written out in full so no carry depends on a lower one.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign co = gg | (gp & ci);

    assign s = p ^ c;

endmodule

// File: rtl/carry_look_ahead.sv
// Registered two-level carry-lookahead adder: 4-bit groups, second-level group carries,
// one-cycle latency with a valid qualifier.
module carry_look_ahead
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    localparam int NG = WIDTH / CLA_GROUP_W;

    if (!cla_width_ok(WIDTH)) begin : g_bad_width
        $error("carry_look_ahead: WIDTH must be a multiple of 4 and at most 16");
    end

    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_c;
    logic [NG-1:0]    grp_co;
    logic [WIDTH-1:0] sum_next;

    // Second level: each group carry-in is an OR of products of group G/P and cin,
    // so every group sees its carry after the same two-level depth.
    always_comb begin
        logic prod;
        logic acc;
        // NOTE: every variable gets a value before any branch or loop, so no latch is inferred.
        grp_c    = '0;
        prod     = 1'b0;
        acc      = 1'b0;
        grp_c[0] = cin;
        for (int k = 1; k < NG; k++) begin
            acc = 1'b0;
            for (int j = 0; j < k; j++) begin
                prod = grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    prod = prod & grp_p[m];
                end
                acc = acc | prod;
            end
            prod = cin;
            for (int m = 0; m < k; m++) begin
                prod = prod & grp_p[m];
            end
            grp_c[k] = acc | prod;
        end
    end

    for (genvar i = 0; i < NG; i++) begin : g_grp
        cla4_group u_grp (
            .a  (a[i*CLA_GROUP_W +: CLA_GROUP_W]),
            .b  (b[i*CLA_GROUP_W +: CLA_GROUP_W]),
            .ci (grp_c[i]),
            .s  (sum_next[i*CLA_GROUP_W +: CLA_GROUP_W]),
            .co (grp_co[i]),
            .gp (grp_p[i]),
            .gg (grp_g[i])
        );
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_next;
                cout <= grp_co[NG-1];
            end
        end
    end

endmodule

// File: tb/tb_carry_look_ahead.sv
// Self-checking bench: WIDTH 4/8/16 instances driven in lockstep against a scoreboard queue.
module tb_carry_look_ahead;

    typedef struct {
        logic        ov;
        logic [16:0] r4;
        logic [16:0] r8;
        logic [16:0] r16;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;

    logic [3:0]  sum4;
    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic        cout4, cout8, cout16;
    logic        ov4, ov8, ov16;

    exp_t        exp_q[$];
    logic [16:0] m4 = '0, m8 = '0, m16 = '0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    carry_look_ahead #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[3:0]), .b(b[3:0]), .cin(cin),
        .sum(sum4), .cout(cout4), .out_valid(ov4)
    );
    carry_look_ahead #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .sum(sum8), .cout(cout8), .out_valid(ov8)
    );
    carry_look_ahead #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .sum(sum16), .cout(cout16), .out_valid(ov16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_w4"},  {ov4,  cout4,  sum4},  32'h0);
        check({tag, "_w8"},  {ov8,  cout8,  sum8},  32'h0);
        check({tag, "_w16"}, {ov16, cout16, sum16}, 32'h0);
    endtask

    // Drive one cycle at the falling edge, push the expected result, compare after the rising edge.
    task automatic step(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                        input logic cc, input string tag);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        a        = aa;
        b        = bb;
        cin      = cc;
        if (v) begin
            m4  = 17'(aa[3:0]) + 17'(bb[3:0]) + 17'(cc);
            m8  = 17'(aa[7:0]) + 17'(bb[7:0]) + 17'(cc);
            m16 = 17'(aa)      + 17'(bb)      + 17'(cc);
        end
        e.ov  = v;
        e.r4  = m4;
        e.r8  = m8;
        e.r16 = m16;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'h1, 32'h0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_ov4"},  ov4,  e.ov);
            check({tag, "_ov8"},  ov8,  e.ov);
            check({tag, "_ov16"}, ov16, e.ov);
            check({tag, "_r4"},   {cout4,  sum4},  e.r4);
            check({tag, "_r8"},   {cout8,  sum8},  e.r8);
            check({tag, "_r16"},  {cout16, sum16}, e.r16);
        end
    endtask

    // Directed WIDTH=4 cases: a, b, cin, expected {cout,sum}.
    logic [3:0] dir_a   [8] = '{4'd3, 4'd2, 4'd9, 4'd10, 4'd3, 4'd2, 4'd9, 4'd10};
    logic [3:0] dir_b   [8] = '{4'd4, 4'd5, 4'd9, 4'd15, 4'd4, 4'd5, 4'd9, 4'd15};
    logic       dir_c   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0] dir_exp [8] = '{5'b01000, 5'b01000, 5'b10011, 5'b11010,
                                5'b00111, 5'b00111, 5'b10010, 5'b11001};

    initial begin
        #1;
        check_zero("reset_hold");
        #2;
        rst_n = 1'b1;
        step(1'b0, 16'h0, 16'h0, 1'b0, "post_release");

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(dir_a[i]), 16'(dir_b[i]), dir_c[i], $sformatf("dir%0d", i));
            check($sformatf("dir%0d_const", i), {cout4, sum4}, 32'(dir_exp[i]));
        end

        step(1'b1, 16'd3, 16'd4, 1'b0, "hold_load");
        step(1'b0, 16'd12, 16'd9, 1'b1, "hold");
        check("hold_const", {ov4, cout4, sum4}, 32'b0_0_0111);

        step(1'b1, 16'h00FF, 16'h0000, 1'b1, "w8_ff");
        check("w8_ff_const", {cout8, sum8}, 32'h100);
        step(1'b1, 16'h000F, 16'h0001, 1'b0, "w8_0f");
        check("w8_0f_const", {cout8, sum8}, 32'h010);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "w16_ff");
        check("w16_ff_const", {cout16, sum16}, 32'h1FFFF);

        // Mid-stream asynchronous reset with a valid input pending.
        step(1'b1, 16'h1234, 16'h5678, 1'b1, "pre_rst");
        #2;
        in_valid = 1'b1;
        a        = 16'hABCD;
        b        = 16'h1111;
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        in_valid = 1'b0;
        m4  = '0;
        m8  = '0;
        m16 = '0;
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        #2;
        rst_n = 1'b1;
        step(1'b0, 16'h5555, 16'hAAAA, 1'b1, "rst_idle");
        step(1'b1, 16'h8000, 16'h8000, 1'b0, "rst_first");

        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "rnd");
        end
        step(1'b0, 16'h0, 16'h0, 1'b0, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
